// File: rtl/bitstream_loader_if.sv
// -----------------------------------------------------------------------------
// bitstream_loader_if
//   Word-stream handshake between a bitstream source and the loader.
//   Parameter WORD_W : width of one bitstream word.
//   Signals:
//     word_in    - bitstream word (source -> loader)
//     word_valid - word_in carries a valid word (source -> loader)
//     word_ready - loader takes word_in this cycle (loader -> source)
//   Modports: master = word source, slave = loader.
// -----------------------------------------------------------------------------
interface bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/bitstream_loader.sv
// -----------------------------------------------------------------------------
// bitstream_loader
//   Feeds the fabric core's serial configuration chain. Parallel words arrive
//   over a valid/ready handshake and are serialized LSB-first onto prog_in with
//   prog_en, one bit per prog_clk cycle. Bit 0 of word 0 enters the chain first.
//   After BITSTREAM_LEN bits the loader sits in DONE with done raised.
//
//   Parameters:
//     BITSTREAM_LEN - total chain length in bits
//     WORD_W        - input word width (ceil(BITSTREAM_LEN/WORD_W) words/load)
//   Ports:
//     prog_clk  - only clock, rising edge
//     prog_rst  - synchronous active-high reset
//     start     - single-cycle load request (honoured in IDLE/DONE only)
//     word_if   - slave side of the word handshake (word_in/valid/ready)
//     prog_in   - registered serial data to the chain
//     prog_en   - registered shift enable to the chain
//     busy      - load in progress (FETCH or SHIFT)
//     done      - last load completed, sticky until start or reset
//     crc       - CRC-16/XMODEM of every shifted bit
//
//   Build option: define LOADER_CRC_EN to build the CRC; without it crc is
//   tied to zero and no CRC logic exists.
// -----------------------------------------------------------------------------
module bitstream_loader #(
  parameter int BITSTREAM_LEN = 4416,
  parameter int WORD_W        = 32
) (
  input  logic               prog_clk,
  input  logic               prog_rst,
  input  logic               start,
  bitstream_loader_if.slave  word_if,
  output logic               prog_in,
  output logic               prog_en,
  output logic               busy,
  output logic               done,
  output logic [15:0]        crc
);

  localparam int CNT_W = $clog2(BITSTREAM_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSTREAM_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  // shreg_r holds the bits not yet placed on prog_in; bit 0 of the current
  // word is already in prog_in_r when the word is accepted.
  logic [WORD_W-1:0] shreg_r;
  // total_cnt_r / bit_idx_r index the bit currently shown on prog_in in SHIFT.
  logic [CNT_W-1:0]  total_cnt_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic              prog_in_r;
  logic              prog_en_r;
  logic              busy_r;
  logic              done_r;

  logic              last_bit_s;
  logic              end_word_s;
  logic              word_ready_s;
  logic              accept_s;
  logic              start_s;

  assign last_bit_s = (total_cnt_r == LAST_BIT);
  assign end_word_s = (bit_idx_r == LAST_IDX);
  assign accept_s   = word_ready_s & word_if.word_valid;
  assign start_s    = start & ((state_r == IDLE) || (state_r == DONE));

  // FSM state register
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = FETCH;
        else       state_nxt_s = IDLE;
      end
      FETCH: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = FETCH;
      end
      SHIFT: begin
        if (last_bit_s)      state_nxt_s = DONE;
        else if (!end_word_s) state_nxt_s = SHIFT;
        else if (accept_s)   state_nxt_s = SHIFT;
        else                 state_nxt_s = FETCH;
      end
      DONE: begin
        if (start) state_nxt_s = FETCH;
        else       state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: ready depends only on state and counters
  always_comb begin
    word_ready_s = 1'b0;
    case (state_r)
      FETCH:   word_ready_s = 1'b1;
      SHIFT:   word_ready_s = end_word_s && !last_bit_s;
      default: word_ready_s = 1'b0;
    endcase
  end

  // Shift register, bit counters and registered chain pins
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      shreg_r     <= '0;
      total_cnt_r <= '0;
      bit_idx_r   <= '0;
      prog_in_r   <= 1'b0;
      prog_en_r   <= 1'b0;
    end else begin
      // Pins idle low unless a bit is presented below.
      prog_in_r <= 1'b0;
      prog_en_r <= 1'b0;
      if (start_s) begin
        total_cnt_r <= '0;
        bit_idx_r   <= '0;
      end else if (accept_s) begin
        // Present bit 0 immediately so a word accepted at edge k shows its
        // first bit in the following cycle; this also keeps reloads gapless.
        shreg_r   <= {1'b0, word_if.word_in[WORD_W-1:1]};
        prog_in_r <= word_if.word_in[0];
        prog_en_r <= 1'b1;
        bit_idx_r <= '0;
        if (state_r == SHIFT) total_cnt_r <= total_cnt_r + CNT_W'(1);
        else                  total_cnt_r <= total_cnt_r;
      end else if ((state_r == SHIFT) && !last_bit_s) begin
        total_cnt_r <= total_cnt_r + CNT_W'(1);
        if (!end_word_s) begin
          shreg_r   <= {1'b0, shreg_r[WORD_W-1:1]};
          prog_in_r <= shreg_r[0];
          prog_en_r <= 1'b1;
          bit_idx_r <= bit_idx_r + IDX_W'(1);
        end else begin
          // Word exhausted with no replacement: stall in FETCH.
          bit_idx_r <= bit_idx_r;
        end
      end else begin
        // Last bit or waiting: counters hold; partial-word leftovers dropped.
        total_cnt_r <= total_cnt_r;
        bit_idx_r   <= bit_idx_r;
      end
    end
  end

  // Registered status flags, aligned with the state register
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == FETCH) || (state_nxt_s == SHIFT);
      done_r <= (state_nxt_s == DONE);
    end
  end

  assign word_if.word_ready = word_ready_s;
  assign prog_in            = prog_in_r;
  assign prog_en            = prog_en_r;
  assign busy               = busy_r;
  assign done               = done_r;

`ifdef LOADER_CRC_EN
  // CRC-16/XMODEM single-bit step: MSB feedback, poly 0x1021.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_i,
                                              input logic        bit_i);
    logic fb;
    fb = crc_i[15] ^ bit_i;
    return {crc_i[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc_r;

  // CRC over every bit presented with prog_en, cleared by an accepted start
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      crc_r <= 16'h0000;
    end else if (start_s) begin
      crc_r <= 16'h0000;
    end else if (prog_en_r) begin
      crc_r <= crc16_step(crc_r, prog_in_r);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_bitstream_loader.sv
// -----------------------------------------------------------------------------
// tb_bitstream_loader
//   Three loader instances share one clock and reset:
//     u_big  - default parameters (4416 bits, 32-bit words)
//     u_part - 40-bit chain, partial final word
//     u_crc  - 16-bit chain, table of single-word loads with CRC expectations
// -----------------------------------------------------------------------------
module tb_bitstream_loader;

  logic clk;
  logic rst;
  logic start_big, start_part, start_crc;
  logic in_big, en_big, busy_big, done_big;
  logic in_part, en_part, busy_part, done_part;
  logic in_crc, en_crc, busy_crc, done_crc;
  logic [15:0] crc_big, crc_part, crc_crc;

  int checks;
  int failures;

  bitstream_loader_if #(.WORD_W(32)) if_big ();
  bitstream_loader_if #(.WORD_W(32)) if_part ();
  bitstream_loader_if #(.WORD_W(32)) if_crc ();

  bitstream_loader #(.BITSTREAM_LEN(4416), .WORD_W(32)) u_big (
    .prog_clk(clk), .prog_rst(rst), .start(start_big), .word_if(if_big),
    .prog_in(in_big), .prog_en(en_big), .busy(busy_big), .done(done_big),
    .crc(crc_big)
  );

  bitstream_loader #(.BITSTREAM_LEN(40), .WORD_W(32)) u_part (
    .prog_clk(clk), .prog_rst(rst), .start(start_part), .word_if(if_part),
    .prog_in(in_part), .prog_en(en_part), .busy(busy_part), .done(done_part),
    .crc(crc_part)
  );

  bitstream_loader #(.BITSTREAM_LEN(16), .WORD_W(32)) u_crc (
    .prog_clk(clk), .prog_rst(rst), .start(start_crc), .word_if(if_crc),
    .prog_in(in_crc), .prog_en(en_crc), .busy(busy_crc), .done(done_crc),
    .crc(crc_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_bits;
    logic [15:0] exp_crc;
  } crc_vec_t;

  crc_vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One load of 138 x 32'hA5A5_0F0F into u_big, with optional stalls before
  // words 5 and 100, an optional reset at a given bit and an optional start
  // pulse in the middle of the load.
  task automatic run_big(input string tag, input bit stalls, input int rst_bit,
                         input int start_bit);
    logic [31:0] pat;
    int n, acc, gap, zeros, run, max_run, errs, s5, s100;
    bit seen, fin, pulsed, did_rst;
    pat = 32'hA5A5_0F0F;
    n = 0; acc = 0; gap = 0; zeros = 0; run = 0; max_run = 0; errs = 0;
    s5 = 0; s100 = 0; seen = 1'b0; fin = 1'b0; pulsed = 1'b0; did_rst = 1'b0;
    if_big.word_valid = 1'b0;
    start_big = 1'b1;
    tick();
    start_big = 1'b0;
    chk({tag, "/ready_after_start"}, if_big.word_ready, 1);
    chk({tag, "/done_cleared"}, done_big, 0);
    chk({tag, "/busy_fetch"}, busy_big, 1);
    chk({tag, "/en_fetch"}, en_big, 0);
    for (int cyc = 0; cyc < 6000 && !fin && !did_rst; cyc++) begin
      if (stalls && if_big.word_ready && acc == 5 && s5 < 3) begin
        if_big.word_valid = 1'b0;
        s5++;
      end else if (stalls && if_big.word_ready && acc == 100 && s100 < 3) begin
        if_big.word_valid = 1'b0;
        s100++;
      end else begin
        if_big.word_valid = 1'b1;
      end
      if_big.word_in = pat;
      if (if_big.word_ready && if_big.word_valid) acc++;
      start_big = (start_bit >= 0) && (n >= start_bit) && !pulsed;
      if (start_big) pulsed = 1'b1;
      if (rst_bit >= 0 && n == rst_bit) begin
        rst = 1'b1;
        did_rst = 1'b1;
      end
      tick();
      start_big = 1'b0;
      rst = 1'b0;
      if (did_rst) begin
        chk({tag, "/rst_prog_in"}, in_big, 0);
        chk({tag, "/rst_prog_en"}, en_big, 0);
        chk({tag, "/rst_busy"}, busy_big, 0);
        chk({tag, "/rst_done"}, done_big, 0);
        chk({tag, "/rst_ready"}, if_big.word_ready, 0);
        chk({tag, "/rst_crc"}, crc_big, 0);
      end else begin
        if (en_big) begin
          if (seen) gap += zeros;
          zeros = 0;
          seen = 1'b1;
          if (in_big !== pat[n % 32]) errs++;
          n++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
          if (seen) zeros++;
        end
        if (done_big) fin = 1'b1;
      end
    end
    if_big.word_valid = 1'b0;
    if (did_rst) begin
      tick();
      chk({tag, "/idle_ready"}, if_big.word_ready, 0);
      chk({tag, "/idle_en"}, en_big, 0);
      chk({tag, "/idle_busy"}, busy_big, 0);
    end else begin
      chk({tag, "/done_seen"}, fin, 1);
      chk({tag, "/en_cycles"}, n, 4416);
      chk({tag, "/stall_gap"}, gap, stalls ? 6 : 0);
      chk({tag, "/bit_errors"}, errs, 0);
      chk({tag, "/longest_run"}, max_run, stalls ? 3040 : 4416);
      chk({tag, "/words"}, acc, 138);
      chk({tag, "/busy_done"}, busy_big, 0);
      chk({tag, "/ready_done"}, if_big.word_ready, 0);
      if_big.word_valid = 1'b1;
      tick();
      tick();
      if_big.word_valid = 1'b0;
      chk({tag, "/done_sticky"}, done_big, 1);
      chk({tag, "/en_after"}, en_big, 0);
    end
  endtask

  // Two words into the 40-bit chain; the top 24 bits of word 1 are dropped.
  task automatic run_part();
    logic [39:0] got;
    logic [31:0] words [2];
    int n, acc;
    bit fin;
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_00AA;
    got = '0; n = 0; acc = 0; fin = 1'b0;
    start_part = 1'b1;
    tick();
    start_part = 1'b0;
    chk("part/ready_after_start", if_part.word_ready, 1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if_part.word_valid = 1'b1;
      if_part.word_in = (acc < 2) ? words[acc] : 32'h5555_5555;
      if (if_part.word_ready) acc++;
      tick();
      if (en_part) begin
        if (n < 40) got[n] = in_part;
        n++;
      end
      if (done_part) fin = 1'b1;
    end
    chk("part/done_seen", fin, 1);
    chk("part/bits", got, {8'hAA, 32'hFFFF_FFFF});
    chk("part/en_cycles", n, 40);
    chk("part/words", acc, 2);
    chk("part/busy_done", busy_part, 0);
    chk("part/ready_done", if_part.word_ready, 0);
    if_part.word_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start_big = 1'b0; start_part = 1'b0; start_crc = 1'b0;
    if_big.word_valid = 1'b0;  if_big.word_in = 32'h0;
    if_part.word_valid = 1'b0; if_part.word_in = 32'h0;
    if_crc.word_valid = 1'b0;  if_crc.word_in = 32'h0;

    vecs[0] = '{32'h0000_0001, 16'h0001, 16'h1B98};
    vecs[1] = '{32'hDEAD_0000, 16'h0000, 16'h0000};
    vecs[2] = '{32'h0000_8000, 16'h8000, 16'h1021};
    vecs[3] = '{32'h1234_4000, 16'h4000, 16'h2042};
    vecs[4] = '{32'hFFFF_C000, 16'hC000, 16'h3063};

    // Reset state
    tick();
    tick();
    chk("reset/ready", if_big.word_ready, 0);
    chk("reset/prog_in", in_big, 0);
    chk("reset/prog_en", en_big, 0);
    chk("reset/busy", busy_big, 0);
    chk("reset/done", done_big, 0);
    chk("reset/crc", crc_big, 0);

    // start together with reset: reset wins
    start_big = 1'b1;
    tick();
    rst = 1'b0;
    start_big = 1'b0;
    tick();
    chk("rst_start/ready", if_big.word_ready, 0);
    chk("rst_start/busy", busy_big, 0);

    run_part();

    // Table: one word per load into the 16-bit chain
    for (int v = 0; v < 5; v++) begin
      logic [15:0] got;
      int n, acc;
      bit fin;
      got = '0; n = 0; acc = 0; fin = 1'b0;
      start_crc = 1'b1;
      tick();
      start_crc = 1'b0;
      chk($sformatf("crc%0d/ready_after_start", v), if_crc.word_ready, 1);
      chk($sformatf("crc%0d/crc_cleared", v), crc_crc, 0);
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
        if_crc.word_valid = 1'b1;
        if_crc.word_in = vecs[v].word;
        if (if_crc.word_ready) acc++;
        tick();
        if (en_crc) begin
          if (n < 16) got[n] = in_crc;
          n++;
        end
        if (done_crc) fin = 1'b1;
      end
      chk($sformatf("crc%0d/done_seen", v), fin, 1);
      chk($sformatf("crc%0d/bits", v), got, vecs[v].exp_bits);
      chk($sformatf("crc%0d/en_cycles", v), n, 16);
      chk($sformatf("crc%0d/words", v), acc, 1);
`ifdef LOADER_CRC_EN
      chk($sformatf("crc%0d/crc", v), crc_crc, vecs[v].exp_crc);
`else
      chk($sformatf("crc%0d/crc", v), crc_crc, 16'h0000);
`endif
      tick();
      if_crc.word_valid = 1'b0;
`ifdef LOADER_CRC_EN
      chk($sformatf("crc%0d/crc_held", v), crc_crc, vecs[v].exp_crc);
`else
      chk($sformatf("crc%0d/crc_held", v), crc_crc, 16'h0000);
`endif
      chk($sformatf("crc%0d/done_sticky", v), done_crc, 1);
    end

    run_big("gapless", 1'b0, -1, -1);
    run_big("stalls", 1'b1, -1, -1);
    run_big("reset_mid", 1'b0, 1000, -1);
    run_big("start_mid", 1'b0, -1, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

Upstream feeder for the fabric core's serial configuration chain. It accepts the configuration bitstream as parallel words over a valid/ready handshake and serializes it LSB-first onto the core's `prog_in`/`prog_en` pins, one bit per `prog_clk` cycle. Bit 0 of word 0 enters the chain first, so software can store the bitstream as a plain little-endian word array. On completion it raises `done`, and it can optionally report a CRC of every bit shifted.

## Interface
- `BITSTREAM_LEN`, default 4416: total chain length in bits.
- `WORD_W`, default 32: input word width. The block consumes ceil(BITSTREAM_LEN/WORD_W) words.
- `prog_clk`  input  1: the only clock. All logic is on the rising edge.
- `prog_rst`  input  1: reset, synchronous and active-high.
- `start`  input  1: single-cycle request to begin a load.
- `word_in`  input  WORD_W: bitstream word.
- `word_valid`  input  1: `word_in` is valid.
- `word_ready`  output  1: the loader accepts `word_in` this cycle.
- `prog_in`  output  1: serial data to the core chain.
- `prog_en`  output  1: shift enable to the core chain.
- `busy`  output  1: a load is in progress.
- `done`  output  1: the last load completed. Sticky until the next `start` or reset.
- `crc`  output  16: CRC of the shifted bits (see Configuration).

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - `start` moves the FSM to FETCH and clears the bit counter and CRC.
  - `busy` is high in FETCH and SHIFT only.
- FETCH:
  - `word_ready`=1.
  - On `word_valid && word_ready`, load `word_in` into the shift register and go to SHIFT.
- SHIFT:
  - Each cycle drives shreg[0] on `prog_in` with `prog_en`=1, then shifts right and increments the bit counters (`total_cnt`, `bit_idx`).
- End of word (`bit_idx`==WORD_W-1) with bits remaining:
  - `word_ready`=1 in that cycle.
  - If a word is accepted, go straight to its bit 0 next cycle (gapless). Otherwise go to FETCH.
- End of stream (`total_cnt`==BITSTREAM_LEN-1):
  - Go to DONE.
  - Unshifted high bits of a partial final word are discarded.
- DONE: `done`=1 and `word_ready`=0. `start` clears `done` and re-enters FETCH.
- `start` is ignored in FETCH and SHIFT.
- `word_valid` is ignored whenever `word_ready`=0.
- `word_ready` is a combinational function of state and counters only. It never depends on `word_valid`.
- The bit counter is $clog2(BITSTREAM_LEN+1) bits wide and never wraps within a load.

## Timing
- Reset value of every output is 0: `word_ready`, `prog_in`, `prog_en`, `busy`, `done`, `crc`.
- `prog_in` and `prog_en` are registered.
- `start` sampled at edge 0 → `word_ready`=1 in the cycle after edge 0.
- Word accepted at edge k → its bit 0 appears on `prog_in` with `prog_en`=1 in the cycle after edge k.
- Each bit is held for exactly one cycle.
- Stalls:
  - While waiting in FETCH, `prog_en`=0 and `prog_in`=0. The chain holds its contents.
  - Exactly BITSTREAM_LEN cycles with `prog_en`=1 occur per load, regardless of stalls.
- Last bit: `prog_en` falls and `done` rises on the same edge that ends the last-bit cycle.
- Gapless load: with `word_valid` held high, `prog_en` is high for BITSTREAM_LEN consecutive cycles.
- Reset mid-load: at the reset edge, all state returns to IDLE with outputs 0. The partially shifted chain is left as-is. No abort handshake.
- `start` and `prog_rst` asserted together: reset wins.

## Configuration
- `LOADER_CRC_EN` defined:
  - `crc` is CRC-16/XMODEM: poly 0x1021, init 0x0000, bit-serial, MSB feedback, no reflection, no final XOR.
  - Update rule per shifted bit b: fb = crc[15]^b; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - Updated on every `prog_en` cycle, cleared on `start`, held in DONE.
- `LOADER_CRC_EN` undefined: `crc` is tied to 16'h0000 and no CRC logic is built.

## Test plan
- Gapless load, default parameters: 138 words of 32'hA5A5_0F0F with `word_valid` always high → `prog_en` high for 4416 consecutive cycles; `prog_in` sequence is 1,1,1,1,0,0,0,0,… repeating per word; `done`=1 the cycle after the last bit; `busy`=0 from then on.
- Stalls: `word_valid` dropped for 3 cycles before words 5 and 100 → `prog_en`=0 for exactly those 3+3 cycles; total `prog_en` cycles = 4416; bit order unchanged.
- Partial final word (BITSTREAM_LEN=40): words 32'hFFFF_FFFF, 32'h0000_00AA → 32 ones, then bits 0,1,0,1,0,1,0,1; `prog_en` cycles = 40; `done` after the 40th bit.
- Reset and ignored start:
  - Assert `prog_rst` for 1 cycle at bit 1000 → next cycle all outputs 0 and state IDLE.
  - A new `start` then performs a full 4416-bit load.
  - `start` pulsed mid-load has no effect.
- CRC (LOADER_CRC_EN defined, BITSTREAM_LEN=16): single word 16'h0001 → `crc`=16'h1B98 in DONE. Same stimulus with the macro undefined → `crc`=0.
